data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Slave end of the data-memory interface driven by the memory_access stage.
- Accepts one load/store request at a time over a req/addr_ok/data_ok handshake.
- Holds a word-addressed on-chip RAM and returns load data or store completion after a programmable fixed latency.
- Flags misaligned and out-of-range accesses so the pipeline can raise AdEL/AdES.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words. Power of two, at least 16.
- LATENCY, 1: cycles from request acceptance to data_ok. Legal range 1..8.

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-high
- req  input  1  request valid from memory_access
- wr  input  1  1 = store, 0 = load
- size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned
- addr  input  32  byte address
- wdata  input  32  store data, right-justified (SB uses [7:0], SH uses [15:0])
- addr_ok  output  1  request accepted this cycle when req && addr_ok
- data_ok  output  1  one-cycle response pulse
- rdata  output  32  full aligned RAM word; the requester extends and selects the byte/half
- err  output  1  qualified by data_ok; 1 = misaligned or out-of-range access

Behaviour:
- Reset (rst high at a rising edge):
  - state goes to IDLE; data_ok=0, rdata=0, err=0, latency counter=0.
  - RAM contents are not reset.
- States: IDLE, WAIT, RESP.
- addr_ok = (state==IDLE) || (state==RESP). It is combinational from state only, never from req.
- Acceptance edge (req && addr_ok):
  - Latch wr, err_next, and the read word.
  - If LATENCY==1, go to RESP. Otherwise go to WAIT with cnt=LATENCY-1.
- WAIT: decrement cnt each cycle; move to RESP when cnt reaches 1. data_ok goes high exactly LATENCY cycles after the acceptance edge.
- RESP: data_ok=1 for exactly one cycle.
  - If req is high in this cycle, the new request is accepted, so back-to-back throughput is one request per LATENCY cycles.
  - Otherwise return to IDLE.
- rdata and err hold their values until the next data_ok.
- Misaligned (err_next=1) when any of these hold:
  - size==1 and addr[0]==1
  - size==2 and addr[1:0]!=0
  - size==3
- Out-of-range (err_next=1): addr[31:2] >= DEPTH_WORDS.
- Index: addr[2+log2(DEPTH_WORDS)-1:2].
- Store on the acceptance edge, only if err_next==0. Byte strobes:
  - byte: 1 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Store lane data:
  - byte: wdata[7:0] replicated to all 4 lanes
  - half: wdata[15:0] replicated to both halves
  - word: wdata
  - Only strobed lanes are written.
- Load read is sampled on the acceptance edge; it always sees every previously accepted store. A load with err_next=1 returns rdata=0.
- Store response: data_ok pulses with err valid and rdata=0.
- Response ordering: responses return in acceptance order; only one request is ever outstanding.
- Reset mid-operation:
  - A pending response is dropped and no data_ok is issued.
  - A store accepted before reset stays committed.
- req, wr, size, addr and wdata are don't-care when not accepted.
- Inputs may change after acceptance; the block holds no dependency on them.

Test Plan:
- Reset check: hold rst 2 cycles -> data_ok=0, rdata=0, err=0, addr_ok=1 on the first cycle after reset.
- Word round trip, LATENCY=1:
  - SW addr=0x10, wdata=0xDEADBEEF -> data_ok next cycle, err=0.
  - LW 0x10 -> data_ok after 1 cycle, rdata=0xDEADBEEF.
- Byte/half lanes:
  - After SW 0x20=0x00000000, do SB 0x21 wdata=0x5A, then SH 0x22 wdata=0x1234.
  - LW 0x20 -> rdata=0x12345A00.
- Errors:
  - LH 0x31 -> err=1, rdata=0.
  - SW 0x06 -> err=1, and a subsequent LW 0x04 shows an unchanged word.
  - LW addr=4*DEPTH_WORDS -> err=1.
- LATENCY=3 back-to-back:
  - req held high with LW 0x10 then LW 0x20 -> data_ok at cycles T+3 and T+6 with the correct words.
  - addr_ok=0 during WAIT.
- Reset mid-WAIT (LATENCY=4):
  - SW 0x40=0xCAFEF00D accepted, then rst at T+2 -> no data_ok.
  - After reset, LW 0x40 -> rdata=0xCAFEF00D.

Source files
------------

// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Slave end of the data-memory port used by the memory_access stage.
//   It accepts one load or store at a time over a req/addr_ok/data_ok
//   handshake. Each response comes back a fixed LATENCY cycles after the
//   request is accepted. Misaligned and out-of-range accesses are flagged
//   on err so the pipeline can raise AdEL/AdES.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous, active-high reset (RAM contents are kept)
//   req      request valid
//   wr       1 = store, 0 = load
//   size     0 = byte, 1 = half, 2 = word, 3 = illegal
//   addr     byte address
//   wdata    store data, right-justified
//   addr_ok  request accepted this cycle when req && addr_ok
//   data_ok  one-cycle response pulse
//   rdata    full aligned RAM word for loads, 0 for stores and errors
//   err      misaligned / out-of-range flag, qualified by data_ok
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing outstanding, ready to accept
// WAIT  | request accepted, counting down the remaining latency
// RESP  | data_ok asserted this cycle; a new request may be accepted
module data_sram_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_rdata_q;
    logic        pend_err_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept;
    logic             misalign;
    logic             out_of_range;
    logic             err_next;
    logic [IDX_W-1:0] idx;
    logic [3:0]       strb;
    logic [31:0]      lane_data;
    logic [31:0]      acc_rdata;

    assign addr_ok = (state_q == IDLE) || (state_q == RESP);
    assign data_ok = (state_q == RESP);
    assign rdata   = rdata_q;
    assign err     = err_q;

    assign accept = req && addr_ok;

    assign misalign = ((size == 2'd1) && addr[0])
                   || ((size == 2'd2) && (addr[1:0] != 2'b00))
                   || (size == 2'd3);
    // The depth is a power of two, so any set bit above the index is out of range.
    assign out_of_range = |addr[31:2+IDX_W];
    assign err_next     = misalign || out_of_range;
    assign idx          = addr[2+IDX_W-1:2];

    always_comb begin
        strb      = 4'b1111;
        lane_data = wdata;
        case (size)
            2'd0: begin
                strb      = 4'b0001 << addr[1:0];
                lane_data = {4{wdata[7:0]}};
            end
            2'd1: begin
                strb      = 4'b0011 << addr[1:0];
                lane_data = {2{wdata[15:0]}};
            end
            default: begin
                strb      = 4'b1111;
                lane_data = wdata;
            end
        endcase
    end

    // Stores and errored loads return zero. The RAM is read on the
    // acceptance edge, so every earlier store is already visible.
    assign acc_rdata = (wr || err_next) ? 32'd0 : mem_q[idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end else if (state_q == RESP) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            pend_rdata_q <= 32'd0;
            pend_err_q   <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                pend_rdata_q <= acc_rdata;
                pend_err_q   <= err_next;
            end
            // Visible outputs change only when a response is presented,
            // so they hold between data_ok pulses. With LATENCY==1 the
            // response follows the acceptance edge directly.
            if (state_d == RESP) begin
                rdata_q <= accept ? acc_rdata : pend_rdata_q;
                err_q   <= accept ? err_next  : pend_err_q;
            end
        end
    end

    // RAM has no reset; a store commits on its acceptance edge.
    always_ff @(posedge clk) begin
        if (!rst && accept && wr && !err_next) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    mem_q[idx][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req [3];
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok [3];
    logic        data_ok [3];
    logic [31:0] rdata [3];
    logic        err [3];

    int lat [3] = '{1, 3, 4};
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t sbq [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_sram_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req(req[0]), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]),
        .rdata(rdata[0]), .err(err[0])
    );

    data_sram_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .req(req[1]), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]),
        .rdata(rdata[1]), .err(err[1])
    );

    data_sram_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .req(req[2]), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(addr_ok[2]), .data_ok(data_ok[2]),
        .rdata(rdata[2]), .err(err[2])
    );

    // Scoreboard consumer: every data_ok must match the oldest expected
    // response for that instance, including the cycle it appears in.
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1) begin
            for (int k = 0; k < 3; k++) begin
                if (data_ok[k] === 1'b1) begin
                    checks++;
                    if (sbq[k].size() == 0) begin
                        errors++;
                        $display("FAIL spurious_data_ok inst=%0d cyc=%0d rdata=%h err=%b expected no response",
                                 k, cyc, rdata[k], err[k]);
                    end else begin
                        e = sbq[k].pop_front();
                        if (rdata[k] !== e.rdata || err[k] !== e.err || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL response inst=%0d got rdata=%h err=%b cyc=%0d expected rdata=%h err=%b cyc=%0d",
                                     k, rdata[k], err[k], cyc, e.rdata, e.err, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int k, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err);
        int waited = 0;
        @(negedge clk);
        req[k] = 1'b1;
        wr     = w;
        size   = sz;
        addr   = a;
        wdata  = d;
        while (addr_ok[k] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (addr_ok[k] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout inst=%0d addr=%h addr_ok=%b expected 1", k, a, addr_ok[k]);
            req[k] = 1'b0;
        end else begin
            sbq[k].push_back('{exp_rd, exp_err, cyc + lat[k]});
            @(posedge clk);
        end
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        req[k] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d/%0d/%0d expected 0/0/0",
                     sbq[0].size(), sbq[1].size(), sbq[2].size());
            for (int k = 0; k < 3; k++) sbq[k].delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks += 4;
            if (data_ok[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_data_ok inst=%0d got %b expected 0", k, data_ok[k]);
            end
            if (rdata[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_rdata inst=%0d got %h expected 0", k, rdata[k]);
            end
            if (err[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_err inst=%0d got %b expected 0", k, err[k]);
            end
            if (addr_ok[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_addr_ok inst=%0d got %b expected 1", k, addr_ok[k]);
            end
        end
    endtask

    task automatic test_word_l1();
        issue(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(0, 1'b0, 2'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        idle(0);
        drain();
    endtask

    task automatic test_lanes();
        issue(0, 1'b1, 2'd2, 32'h20, 32'h00000000, 32'h0, 1'b0);
        issue(0, 1'b1, 2'd0, 32'h21, 32'hFFFFFF5A, 32'h0, 1'b0);
        issue(0, 1'b1, 2'd1, 32'h22, 32'hABCD1234, 32'h0, 1'b0);
        issue(0, 1'b0, 2'd2, 32'h20, 32'h0, 32'h12345A00, 1'b0);
        issue(0, 1'b0, 2'd1, 32'h22, 32'h0, 32'h12345A00, 1'b0);
        issue(0, 1'b0, 2'd0, 32'h21, 32'h0, 32'h12345A00, 1'b0);
        idle(0);
        drain();
    endtask

    task automatic test_errors();
        issue(0, 1'b0, 2'd1, 32'h31, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b1, 2'd2, 32'h04, 32'h11112222, 32'h0, 1'b0);
        issue(0, 1'b1, 2'd2, 32'h06, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(0, 1'b0, 2'd2, 32'h04, 32'h0, 32'h11112222, 1'b0);
        issue(0, 1'b0, 2'd2, 32'h100, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b1, 2'd2, 32'h80000004, 32'h55555555, 32'h0, 1'b1);
        issue(0, 1'b0, 2'd3, 32'h04, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b0, 2'd2, 32'h04, 32'h0, 32'h11112222, 1'b0);
        issue(0, 1'b1, 2'd2, 32'hFC, 32'h0BADF00D, 32'h0, 1'b0);
        issue(0, 1'b0, 2'd2, 32'hFC, 32'h0, 32'h0BADF00D, 1'b0);
        idle(0);
        drain();
        repeat (3) @(negedge clk);
        checks++;
        if (rdata[0] !== 32'h0BADF00D || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL rdata_hold got rdata=%h err=%b expected rdata=0badf00d err=0", rdata[0], err[0]);
        end
    endtask

    task automatic test_back_to_back_l3();
        issue(1, 1'b1, 2'd2, 32'h10, 32'h01010101, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (addr_ok[1] !== 1'b0) begin
            errors++;
            $display("FAIL addr_ok_wait got %b expected 0", addr_ok[1]);
        end
        issue(1, 1'b1, 2'd2, 32'h20, 32'h02020202, 32'h0, 1'b0);
        issue(1, 1'b0, 2'd2, 32'h10, 32'h0, 32'h01010101, 1'b0);
        issue(1, 1'b0, 2'd2, 32'h20, 32'h0, 32'h02020202, 1'b0);
        idle(1);
        @(negedge clk);
        checks++;
        if (addr_ok[1] !== 1'b0) begin
            errors++;
            $display("FAIL addr_ok_wait2 got %b expected 0", addr_ok[1]);
        end
        drain();
    endtask

    task automatic test_reset_mid_wait();
        issue(2, 1'b1, 2'd2, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        sbq[2].delete();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (data_ok[2] !== 1'b0) begin
                errors++;
                $display("FAIL reset_drop cyc=%0d data_ok=%b expected 0", cyc, data_ok[2]);
            end
        end
        issue(2, 1'b0, 2'd2, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0);
        idle(2);
        drain();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) req[k] = 1'b0;
        rst   = 1'b1;
        wr    = 1'b0;
        size  = 2'd0;
        addr  = 32'd0;
        wdata = 32'd0;
        test_reset();
        test_word_l1();
        test_lanes();
        test_errors();
        test_back_to_back_l3();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached at cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
